// File: rtl/game_event_tx_queue_if.sv
// game_event_tx_queue_if
// Byte-launch link between the event queue and the UART transmitter.
// master: queue side (drives tx_start/tx_data, observes tx_busy).
// slave : transmitter side.
interface game_event_tx_queue_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/game_event_tx_queue.sv
// game_event_tx_queue
// Turns one-cycle game events (game over 'R', hit 'H', mole '0'..'4') into
// bytes, queues them in a DEPTH-entry FIFO and launches them one at a time
// to a UART transmitter through a tx_start / tx_busy handshake.
// Optional build macro: EVT_MOLE_COALESCE_EN -- drops a mole event whose
// byte repeats the last mole byte enqueued since the last clear/reset.
module game_event_tx_queue #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     evt_gameover,
    input  logic                     evt_hit,
    input  logic                     evt_mole,
    input  logic [2:0]               evt_mole_index,
    game_event_tx_queue_if.master    tx,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [AW-1:0] ack_cnt;
    logic [7:0]    tx_data_q;

    logic          evt_req;
    logic [7:0]    evt_byte;
    logic          evt_drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          ovf_set;

`ifdef EVT_MOLE_COALESCE_EN
    logic [7:0]    last_mole;
    logic          last_mole_vld;
    logic          mole_sel;
`endif

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // Pick the highest-priority event this cycle and encode its byte
    always_comb begin
        evt_req  = 1'b0;
        evt_byte = '0;
        evt_drop = 1'b0;
`ifdef EVT_MOLE_COALESCE_EN
        mole_sel = 1'b0;
`endif
        if (evt_gameover) begin
            evt_req  = 1'b1;
            evt_byte = 8'h52;
            evt_drop = evt_hit | evt_mole;
        end else if (evt_hit) begin
            evt_req  = 1'b1;
            evt_byte = 8'h48;
            evt_drop = evt_mole;
        end else if (evt_mole && (evt_mole_index <= 3'd4)) begin
            evt_byte = 8'h30 + {5'b0, evt_mole_index};
`ifdef EVT_MOLE_COALESCE_EN
            mole_sel = 1'b1;
            evt_req  = !(last_mole_vld && (last_mole == evt_byte));
`else
            evt_req  = 1'b1;
`endif
        end
    end

    // A flush suppresses both sides of the FIFO; a launch is not started
    // in the flush cycle so flushed bytes are never sent.
    assign push    = evt_req && !fifo_full && !clear;
    assign pop     = (state == IDLE) && !fifo_empty && !tx.tx_busy && !clear;
    assign ovf_set = !clear && (evt_drop || (evt_req && fifo_full));

    // FIFO storage write (no reset needed on the data array)
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= evt_byte;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef EVT_MOLE_COALESCE_EN
    // Remember the last mole byte actually enqueued
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_mole     <= '0;
            last_mole_vld <= 1'b0;
        end else if (clear) begin
            last_mole_vld <= 1'b0;
        end else if (push && mole_sel) begin
            last_mole     <= evt_byte;
            last_mole_vld <= 1'b1;
        end
    end
`endif

    // Launch FSM: pop head, pulse tx_start, wait for busy (or time out), wait for done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ack_cnt   <= '0;
            tx_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= LAUNCH;
                        tx_data_q <= mem[rd_ptr];
                    end
                end
                LAUNCH: begin
                    state   <= WAIT_ACK;
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (tx.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        state <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx.tx_start = (state == LAUNCH);
    assign tx.tx_data  = tx_data_q;

endmodule
